// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage.
// Holds widths, LUT depth and the FSM state type.
package fetch_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int KEY_W_DEF = 5;
  localparam int LUT_DEPTH = 2 ** KEY_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table.
// Registered write, combinational read, sync clear.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [KEY_W-1:0] widx,
  input  logic [PC_W-1:0]  wdata,
  input  logic [KEY_W-1:0] ridx,
  output logic [PC_W-1:0]  rdata
);

  localparam int DEPTH = 2 ** KEY_W;

  logic [PC_W-1:0] mem [DEPTH];

  // Clear every entry on reset, else write one entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register and run-control FSM.
// Branch targets come from the branch_lut table.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  last_addr,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [KEY_W-1:0] branch_key,
  input  logic             lut_we,
  input  logic [KEY_W-1:0] lut_idx,
  input  logic [PC_W-1:0]  lut_data,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;

  branch_lut #(
    .PC_W  (PC_W),
    .KEY_W (KEY_W)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .widx  (lut_idx),
    .wdata (lut_data),
    .ridx  (branch_key),
    .rdata (target)
  );

  // State and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state / next PC; stall > branch > end > step
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (branch_en) begin
          pc_d = target;
        end else if (pc_q == last_addr) begin
          state_d = DONE;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: vector table, corner
// sequences and random run against a reference model.
module tb_fetch_unit;

  localparam int PC_W  = 10;
  localparam int KEY_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  last_addr;
  logic             stall;
  logic             branch_en;
  logic [KEY_W-1:0] branch_key;
  logic             lut_we;
  logic [KEY_W-1:0] lut_idx;
  logic [PC_W-1:0]  lut_data;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: mode 0=idle 1=run 2=done
  int m_mode;
  int m_pc;
  int m_lut [32];

  fetch_unit #(.PC_W(PC_W), .KEY_W(KEY_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .last_addr  (last_addr),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_key (branch_key),
    .lut_we     (lut_we),
    .lut_idx    (lut_idx),
    .lut_data   (lut_data),
    .pc         (pc),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       st;
    int         la;
    logic       stl;
    logic       br;
    int         key;
    logic       we;
    int         idx;
    int         data;
    int         e_pc;
    logic       e_run;
    logic       e_done;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input int got,
                       input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int pack_out(input int p, input logic r,
                                  input logic d);
    return p * 4 + (r ? 2 : 0) + (d ? 1 : 0);
  endfunction

  // model one clock edge from the architectural rules
  task automatic model_step;
    int nxt_pc;
    int nxt_mode;
    if (reset) begin
      m_mode = 0;
      m_pc   = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    nxt_pc   = m_pc;
    nxt_mode = m_mode;
    if (m_mode == 0) begin
      nxt_pc = 0;
      if (start) nxt_mode = 1;
    end else if (m_mode == 2) begin
      if (start) begin
        nxt_mode = 1;
        nxt_pc   = 0;
      end
    end else begin
      if (stall) nxt_pc = m_pc;
      else if (branch_en) nxt_pc = m_lut[branch_key];
      else if (m_pc == int'(last_addr)) nxt_mode = 2;
      else nxt_pc = (m_pc + 1) % (1 << PC_W);
    end
    if (lut_we) m_lut[lut_idx] = int'(lut_data);
    m_pc   = nxt_pc;
    m_mode = nxt_mode;
  endtask

  task automatic tick(input logic rst, input logic st,
                      input int la, input logic stl,
                      input logic br, input int key,
                      input logic we, input int idx,
                      input int data);
    @(negedge clk);
    reset      = rst;
    start      = st;
    last_addr  = PC_W'(la);
    stall      = stl;
    branch_en  = br;
    branch_key = KEY_W'(key);
    lut_we     = we;
    lut_idx    = KEY_W'(idx);
    lut_data   = PC_W'(data);
    @(posedge clk);
    model_step();
    #1;
    check("model", pack_out(int'(pc), running, done),
          pack_out(m_pc, m_mode == 1, m_mode == 2));
  endtask

  task automatic idle_tick(input int la);
    tick(0, 0, la, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp_out(input string name, input int p,
                         input logic r, input logic d);
    check(name, pack_out(int'(pc), running, done),
          pack_out(p, r, d));
  endtask

  function automatic vec_t mk(input logic rst, input logic st,
                              input int la, input logic stl,
                              input logic br, input int key,
                              input logic we, input int idx,
                              input int data, input int p,
                              input logic r, input logic d);
    vec_t v;
    v.rst = rst; v.st = st; v.la = la; v.stl = stl;
    v.br = br; v.key = key; v.we = we; v.idx = idx;
    v.data = data; v.e_pc = p; v.e_run = r; v.e_done = d;
    return v;
  endfunction

  initial begin
    reset = 1; start = 0; last_addr = '0; stall = 0;
    branch_en = 0; branch_key = '0; lut_we = 0;
    lut_idx = '0; lut_data = '0;
    m_mode = 0; m_pc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;

    // straight-line run, end hold, branch past end, loop back
    vecs.push_back(mk(1,1,3,0,0,0,1,5,7, 0,0,0));
    vecs.push_back(mk(0,1,3,0,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,3,0,0,0,0,0,0, 1,1,0));
    vecs.push_back(mk(0,0,3,0,0,0,0,0,0, 2,1,0));
    vecs.push_back(mk(0,0,3,0,0,0,0,0,0, 3,1,0));
    vecs.push_back(mk(0,0,3,0,0,0,0,0,0, 3,0,1));
    vecs.push_back(mk(0,0,3,1,1,5,0,0,0, 3,0,1));
    vecs.push_back(mk(0,0,3,0,0,0,1,5,20, 3,0,1));
    vecs.push_back(mk(0,1,3,0,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1,3,0,0,0,0,0,0, 1,1,0));
    vecs.push_back(mk(0,0,3,0,0,0,0,0,0, 2,1,0));
    vecs.push_back(mk(0,0,3,0,1,5,0,0,0, 20,1,0));
    vecs.push_back(mk(0,0,3,0,0,0,0,0,0, 21,1,0));
    vecs.push_back(mk(1,0,4,0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,4,1,1,5,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,4,0,0,0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,4,0,0,0,0,0,0, 1,1,0));
    vecs.push_back(mk(0,0,4,0,0,0,0,0,0, 2,1,0));
    vecs.push_back(mk(0,0,4,0,0,0,0,0,0, 3,1,0));
    vecs.push_back(mk(0,0,4,0,0,0,0,0,0, 4,1,0));
    vecs.push_back(mk(0,0,4,0,1,1,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0,4,0,0,0,0,0,0, 1,1,0));

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].st, vecs[i].la, vecs[i].stl,
           vecs[i].br, vecs[i].key, vecs[i].we, vecs[i].idx,
           vecs[i].data);
      exp_out($sformatf("vec%0d", i), vecs[i].e_pc,
              vecs[i].e_run, vecs[i].e_done);
    end

    // stall for 3 cycles at pc=6, branch dropped on the 2nd
    tick(1, 0, 100, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 100, 0, 0, 0, 1, 5, 20);
    for (int i = 0; i < 6; i++) idle_tick(100);
    exp_out("at_pc6", 6, 1, 0);
    tick(0, 0, 100, 1, 0, 0, 0, 0, 0);
    exp_out("stall1", 6, 1, 0);
    tick(0, 0, 100, 1, 1, 5, 0, 0, 0);
    exp_out("stall2_br", 6, 1, 0);
    tick(0, 0, 100, 1, 0, 0, 0, 0, 0);
    exp_out("stall3", 6, 1, 0);
    idle_tick(100);
    exp_out("after_stall", 7, 1, 0);

    // same-cycle write and branch uses old entry
    tick(0, 0, 100, 0, 1, 2, 1, 2, 9);
    exp_out("lut_old", 0, 1, 0);
    tick(0, 0, 100, 0, 1, 2, 0, 0, 0);
    exp_out("lut_new", 9, 1, 0);

    // pc wraps from max to 0
    tick(0, 0, 100, 0, 0, 0, 1, 3, 1023);
    tick(0, 0, 100, 0, 1, 3, 0, 0, 0);
    exp_out("to_max", 1023, 1, 0);
    idle_tick(100);
    exp_out("wrap", 0, 1, 0);

    // reset mid-run at pc=7 clears LUT
    for (int i = 0; i < 7; i++) idle_tick(100);
    exp_out("pre_rst", 7, 1, 0);
    tick(1, 1, 100, 0, 1, 5, 1, 5, 30);
    exp_out("rst_run", 0, 0, 0);
    idle_tick(100);
    exp_out("rst_hold", 0, 0, 0);
    tick(0, 1, 1, 0, 0, 0, 0, 0, 0);
    idle_tick(1);
    tick(0, 0, 1, 0, 1, 5, 0, 0, 0);
    exp_out("lut5_clr", 0, 1, 0);
    idle_tick(1);
    idle_tick(1);
    exp_out("done_again", 1, 0, 1);
    tick(0, 1, 1, 0, 0, 0, 0, 0, 0);
    exp_out("restart", 0, 1, 0);

    // random run against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 40),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 31),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 31),
           ($urandom_range(0, 7) == 0) ?
             $urandom_range(1000, 1023) :
             $urandom_range(0, 45));
      if (running && done) begin
        check("excl", 1, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, giving the instruction address width.
REQ-002 The block SHALL have parameter KEY_W, default 5, giving the branch key width (LUT depth 2**KEY_W = 32).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  begin program execution from address 0.
REQ-006 Port: last_addr  input  PC_W  address of the final instruction of the program.
REQ-007 Port: stall  input  1  hold PC for this cycle.
REQ-008 Port: branch_en  input  1  take branch this cycle (driven by the decode/control stage).
REQ-009 Port: branch_key  input  KEY_W  branch LUT index (instruction bits 4:0).
REQ-010 Port: lut_we  input  1  write enable for the branch-target LUT.
REQ-011 Port: lut_idx  input  KEY_W  LUT write index.
REQ-012 Port: lut_data  input  PC_W  LUT write data (absolute target address).
REQ-013 Port: pc  output  PC_W  current instruction address to instruction memory.
REQ-014 Port: running  output  1  high while in state RUN.
REQ-015 Port: done  output  1  high while in state DONE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; outputs are registered or decoded from state only (no input-to-output combinational path).
REQ-017 IDLE: pc held at 0; start=1 -> RUN next cycle with pc=0.
REQ-018 RUN, priority order: stall=1 -> pc held; else branch_en=1 -> pc <= LUT[branch_key]; else pc==last_addr -> DONE, pc held; else pc <= pc+1.
REQ-019 pc+1 SHALL wrap modulo 2**PC_W (max value -> 0) without error flag.
REQ-020 Branch SHALL win over end-of-program when branch_en=1 and pc==last_addr in the same cycle.
REQ-021 Stall SHALL win over both branch and end-of-program; a stalled branch is dropped, not remembered.
REQ-022 Branch targets SHALL be taken unchecked, including targets greater than last_addr.
REQ-023 DONE: pc and done held; start=1 -> RUN next cycle with pc=0 and done=0.
REQ-024 start SHALL be ignored in RUN; branch_en, branch_key and stall SHALL be ignored in IDLE and DONE.
REQ-025 A LUT write SHALL take effect at the next edge; a same-cycle branch to lut_idx uses the old entry.
REQ-026 LUT writes SHALL be accepted in every state.
REQ-027 running = (state==RUN), done = (state==DONE); never both high.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, pc=0, running=0, done=0, all LUT entries=0, regardless of state or concurrent inputs (including lut_we and start).
REQ-029 Reset asserted mid-RUN SHALL abandon the program; execution resumes only on a later start.

Structure
REQ-030 Shared package fetch_pkg SHALL hold PC_W and KEY_W defaults, LUT_DEPTH, and the state enum type.
REQ-031 The LUT SHALL be a sub-module branch_lut (registered write port, combinational read port, synchronous reset).
REQ-032 The FSM and PC register SHALL live in fetch_unit; no clock gating, no latches.

Verification
REQ-033 Reset, start, last_addr=3, no branches -> pc 0,1,2,3 on successive cycles, then done=1 with pc=3 held.
REQ-034 LUT[5]=20, start, branch_en=1 key=5 at pc=2 -> next pc=20, then 21.
REQ-035 last_addr=4, branch_en=1 key=1 (LUT[1]=0) at pc=4 -> pc=0, running stays 1, done stays 0.
REQ-036 stall=1 for 3 cycles at pc=6 with branch_en=1 on the 2nd -> pc=6 throughout, then pc=7.
REQ-037 Same cycle lut_we idx=2 data=9 (old 0) and branch key=2 -> pc=0; repeat branch next cycle -> pc=9.
REQ-038 reset at pc=7 in RUN -> next cycle IDLE, pc=0, LUT[5] reads 0; start in DONE -> pc=0, running=1.
